// File: rtl/cache_bus_arbiter.sv
// cache_bus_arbiter: round-robin arbiter putting icache/dcache line requests
// onto one memory bus; owner-only response routing, BUSY watchdog abort.
//
// Ports:
//   clk, clr            clock, asynchronous active-low reset
//   ic_bus_* / dc_bus_* cache-side request (en/wr/addr/write) and
//                       response (r/read/err) ports, one set per cache
//   mem_bus_*           registered memory request, memory completion/data
//   owner               00 idle, 01 icache, 10 dcache
module cache_bus_arbiter #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 128,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  ic_bus_en,
  input  logic                  ic_bus_wr,
  input  logic [ADDR_WIDTH-1:0] ic_bus_addr,
  input  logic [DATA_WIDTH-1:0] ic_bus_write,
  output logic                  ic_bus_r,
  output logic [DATA_WIDTH-1:0] ic_bus_read,
  output logic                  ic_bus_err,
  input  logic                  dc_bus_en,
  input  logic                  dc_bus_wr,
  input  logic [ADDR_WIDTH-1:0] dc_bus_addr,
  input  logic [DATA_WIDTH-1:0] dc_bus_write,
  output logic                  dc_bus_r,
  output logic [DATA_WIDTH-1:0] dc_bus_read,
  output logic                  dc_bus_err,
  output logic                  mem_bus_en,
  output logic                  mem_bus_wr,
  output logic [ADDR_WIDTH-1:0] mem_bus_addr,
  output logic [DATA_WIDTH-1:0] mem_bus_write,
  input  logic                  mem_bus_r,
  input  logic [DATA_WIDTH-1:0] mem_bus_read,
  output logic [1:0]            owner
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0] TMO    = 8'(TIMEOUT_CYCLES);
  localparam logic [1:0] OWN_IC = 2'b01;
  localparam logic [1:0] OWN_DC = 2'b10;

  state_t                state;
  logic [7:0]            cnt;
  logic [7:0]            cnt_inc;
  logic                  last_dc;
  logic                  pick_ic;
  logic                  pick_dc;
  logic                  timeout;
  logic [DATA_WIDTH-1:0] rsp_data;

  // Tie goes to whoever was not granted last; a lone
  // requester always wins.
  always_comb begin
    pick_dc  = dc_bus_en & (~ic_bus_en | ~last_dc);
    pick_ic  = ic_bus_en & ~pick_dc;
    cnt_inc  = cnt + 8'd1;
    timeout  = (cnt_inc >= TMO);
    rsp_data = mem_bus_wr ? '0 : mem_bus_read;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state         <= IDLE;
      cnt           <= '0;
      last_dc       <= 1'b0;
      owner         <= '0;
      mem_bus_en    <= 1'b0;
      mem_bus_wr    <= 1'b0;
      mem_bus_addr  <= '0;
      mem_bus_write <= '0;
      ic_bus_r      <= 1'b0;
      ic_bus_read   <= '0;
      ic_bus_err    <= 1'b0;
      dc_bus_r      <= 1'b0;
      dc_bus_read   <= '0;
      dc_bus_err    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          unique case (1'b1)
            pick_dc: begin
              state         <= BUSY;
              owner         <= OWN_DC;
              last_dc       <= 1'b1;
              mem_bus_en    <= 1'b1;
              mem_bus_wr    <= dc_bus_wr;
              mem_bus_addr  <= dc_bus_addr;
              mem_bus_write <= dc_bus_write;
            end
            pick_ic: begin
              state         <= BUSY;
              owner         <= OWN_IC;
              last_dc       <= 1'b0;
              mem_bus_en    <= 1'b1;
              mem_bus_wr    <= ic_bus_wr;
              mem_bus_addr  <= ic_bus_addr;
              mem_bus_write <= ic_bus_write;
            end
            default: begin
              state <= IDLE;
            end
          endcase
        end
        BUSY: begin
          cnt <= cnt_inc;
          // A completion on the timeout edge still counts as normal.
          if (mem_bus_r || timeout) begin
            state       <= RESP;
            mem_bus_en  <= 1'b0;
            ic_bus_r    <= owner[0];
            dc_bus_r    <= owner[1];
            ic_bus_err  <= owner[0] & ~mem_bus_r;
            dc_bus_err  <= owner[1] & ~mem_bus_r;
            ic_bus_read <= (owner[0] && mem_bus_r) ? rsp_data : '0;
            dc_bus_read <= (owner[1] && mem_bus_r) ? rsp_data : '0;
          end
        end
        RESP: begin
          state       <= IDLE;
          owner       <= '0;
          cnt         <= '0;
          ic_bus_r    <= 1'b0;
          ic_bus_read <= '0;
          ic_bus_err  <= 1'b0;
          dc_bus_r    <= 1'b0;
          dc_bus_read <= '0;
          dc_bus_err  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
